// File: rtl/sequence_generator_serial_tx.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB-first rep_cnt times, with GAP idle cycles between repetitions.
// Optional feature macro SEQ_GEN_PARITY_EN appends one even-parity bit after every repetition.
module sequence_generator_serial_tx #(
  parameter int                PAT_W   = 5,
  parameter logic [PAT_W-1:0]  PATTERN = 5'b11011,
  parameter int                CNT_W   = 4,
  parameter int                GAP     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_ext,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_cnt,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done,
  output logic [4:0]       state_out
);

  localparam int BIT_CW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_SHIFT  = 5'b00010,
    ST_PARITY = 5'b00100,
    ST_GAP    = 5'b01000,
    ST_DONE   = 5'b10000
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   shift_q, shift_d;
  logic [BIT_CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [GAP_CW-1:0]  gap_cnt_q, gap_cnt_d;
  logic               seq_out_q, seq_out_d;
  logic               seq_valid_q, seq_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rep_end;

  // Outputs are registered from the current state, so they trail state_out by one cycle.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rep_d       = rep_q;
    gap_cnt_d   = gap_cnt_q;
    seq_out_d   = 1'b0;
    seq_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    rep_end     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (rep_cnt != '0)) begin
          state_d   = ST_SHIFT;
          shift_d   = use_ext ? pat_in : PATTERN;
          rep_d     = rep_cnt;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        seq_out_d   = shift_q[PAT_W-1];
        seq_valid_d = 1'b1;
        busy_d      = 1'b1;
        // Rotate rather than shift so the pattern is intact again for the next repetition.
        shift_d     = {shift_q[PAT_W-2:0], shift_q[PAT_W-1]};
        if (bit_cnt_q == BIT_CW'(PAT_W - 1)) begin
          bit_cnt_d = '0;
`ifdef SEQ_GEN_PARITY_EN
          state_d   = ST_PARITY;
`else
          rep_end   = 1'b1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CW'(1);
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      ST_PARITY: begin
        seq_out_d   = ^shift_q;
        seq_valid_d = 1'b1;
        busy_d      = 1'b1;
        rep_end     = 1'b1;
      end
`endif
      ST_GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q == GAP_CW'(GAP - 1)) begin
          gap_cnt_d = '0;
          state_d   = ST_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_CW'(1);
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // End of a repetition: either finish the transfer or start the next pass.
    if (rep_end) begin
      if (rep_q <= CNT_W'(1)) begin
        rep_d   = '0;
        state_d = ST_DONE;
      end else begin
        rep_d   = rep_q - CNT_W'(1);
        state_d = (GAP > 0) ? ST_GAP : ST_SHIFT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rep_q       <= '0;
      gap_cnt_q   <= '0;
      seq_out_q   <= 1'b0;
      seq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rep_q       <= rep_d;
      gap_cnt_q   <= gap_cnt_d;
      seq_out_q   <= seq_out_d;
      seq_valid_q <= seq_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign seq_out   = seq_out_q;
  assign seq_valid = seq_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_sequence_generator_serial_tx.sv
// Self-checking bench for sequence_generator_serial_tx: two instances (GAP=0 and GAP=2) share stimulus and are
// compared cycle by cycle against per-transfer expected output streams built from the transmission rules.
module tb_sequence_generator_serial_tx;

  localparam int PW = 5;
`ifdef SEQ_GEN_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       start   = 1'b0;
  logic       use_ext = 1'b0;
  logic [4:0] pat_in  = '0;
  logic [3:0] rep_cnt = '0;

  logic       seq_out0, seq_valid0, busy0, done0;
  logic [4:0] state0;
  logic       seq_out2, seq_valid2, busy2, done2;
  logic [4:0] state2;

  int checkCount = 0;
  int passCount  = 0;

  // Expected {seq_out, seq_valid, busy, done} for each cycle after the accepting edge.
  logic [3:0] exp0[$];
  logic [3:0] exp2[$];

  sequence_generator_serial_tx #(.PAT_W(5), .PATTERN(5'b11011), .CNT_W(4), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .use_ext(use_ext), .pat_in(pat_in), .rep_cnt(rep_cnt),
    .seq_out(seq_out0), .seq_valid(seq_valid0), .busy(busy0), .done(done0), .state_out(state0)
  );

  sequence_generator_serial_tx #(.PAT_W(5), .PATTERN(5'b11011), .CNT_W(4), .GAP(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .use_ext(use_ext), .pat_in(pat_in), .rep_cnt(rep_cnt),
    .seq_out(seq_out2), .seq_valid(seq_valid2), .busy(busy2), .done(done2), .state_out(state2)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Reference stream: every repetition is the pattern MSB-first (plus parity when enabled),
  // gaps only between repetitions, then a single done cycle.
  function automatic void buildExpected(input int gap, input logic [4:0] pat, input int reps);
    logic [3:0] q[$];
    q = {};
    for (int r = 0; r < reps; r++) begin
      for (int i = PW - 1; i >= 0; i--) q.push_back({pat[i], 3'b110});
      if (PAR_EN != 0) q.push_back({^pat, 3'b110});
      if (r < reps - 1) for (int g = 0; g < gap; g++) q.push_back(4'b0010);
    end
    q.push_back(4'b0001);
    if (gap == 0) exp0 = q;
    else exp2 = q;
  endfunction

  // One full transfer; inputs are scrambled while the transfer runs to prove they are ignored.
  task automatic applyStimulus(input logic ext, input logic [4:0] pat, input logic [3:0] reps, input string name);
    logic [4:0] sent;
    int n0, n2;
    sent = ext ? pat : 5'b11011;
    buildExpected(0, sent, int'(reps));
    buildExpected(2, sent, int'(reps));
    n0 = exp0.size();
    n2 = exp2.size();
    @(negedge clk);
    start   = 1'b1;
    use_ext = ext;
    pat_in  = ext ? pat : 5'($urandom);
    rep_cnt = reps;
    @(posedge clk);
    for (int n = 1; n <= n2 + 1; n++) begin
      @(negedge clk);
      if (n <= n0) begin
        start   = 1'($urandom);
        use_ext = 1'($urandom);
        pat_in  = 5'($urandom);
        rep_cnt = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s g0 n%0d", name, n), 8'({seq_out0, seq_valid0, busy0, done0}),
                  8'((n <= n0) ? exp0[n-1] : 4'b0000));
      checkOutput($sformatf("%s g2 n%0d", name, n), 8'({seq_out2, seq_valid2, busy2, done2}),
                  8'((n <= n2) ? exp2[n-1] : 4'b0000));
    end
    checkOutput({name, " g0 idle state"}, 8'(state0), 8'(5'b00001));
    checkOutput({name, " g2 idle state"}, 8'(state2), 8'(5'b00001));
  endtask

  // Main sequence: reset, directed transfers, ignored start, mid-frame reset, then random transfers.
  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outputs g0", 8'({seq_out0, seq_valid0, busy0, done0}), 8'h0);
    checkOutput("reset outputs g2", 8'({seq_out2, seq_valid2, busy2, done2}), 8'h0);
    checkOutput("reset state g0", 8'(state0), 8'(5'b00001));
    checkOutput("reset state g2", 8'(state2), 8'(5'b00001));
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b0, 5'b00000, 4'd1, "single");
    applyStimulus(1'b0, 5'b00000, 4'd3, "triple");
    applyStimulus(1'b1, 5'b10010, 4'd2, "ext gap");
    applyStimulus(1'b1, 5'b10110, 4'd1, "ext odd");
    applyStimulus(1'b0, 5'b00000, 4'd15, "max reps");

    @(negedge clk);
    start   = 1'b1;
    rep_cnt = 4'd0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("zero reps g0 n%0d", n), 8'({busy0, done0, seq_valid0}), 8'h0);
      checkOutput($sformatf("zero reps state n%0d", n), 8'(state0), 8'(5'b00001));
    end
    @(negedge clk);
    start = 1'b0;

    @(negedge clk);
    start   = 1'b1;
    use_ext = 1'b0;
    rep_cnt = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abort outputs g0", 8'({seq_out0, seq_valid0, busy0, done0}), 8'h0);
    checkOutput("abort outputs g2", 8'({seq_out2, seq_valid2, busy2, done2}), 8'h0);
    checkOutput("abort state g0", 8'(state0), 8'(5'b00001));
    checkOutput("abort state g2", 8'(state2), 8'(5'b00001));
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("post abort n%0d", n), 8'({done0, done2, busy0, busy2}), 8'h0);
    end
    applyStimulus(1'b0, 5'b00000, 4'd2, "after abort");

    for (int t = 0; t < 30; t++) begin
      applyStimulus(1'($urandom), 5'($urandom), 4'($urandom_range(1, 15)), $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
